bcd_score_converter: RTL

BCD_SCORE_CONVERTER -- requirements
Module: bcd_score_converter

---
 rtl/bcd_score_converter.sv | 109 ++++++++++
 1 files changed

// File: rtl/bcd_score_converter.sv
// bcd_score_converter: sequential double-dabble binary-to-BCD converter with 9999 saturation.
// Optional leading-zero blanking when LEADING_ZERO_BLANK_EN is defined.
module bcd_score_converter #(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          bcd_out,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam int CW = $clog2(BIN_WIDTH + 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] RST_BCD = 16'hFFF0;
`else
  localparam logic [15:0] RST_BCD = 16'h0000;
`endif
  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [19:0]          scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [19:0]          adj;
  logic [15:0]          disp;
  logic                 sat;
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = scratch_q[4*i+:4] >= 4'd5 ? scratch_q[4*i+:4] + 4'd3 : scratch_q[4*i+:4];
  end
  // five-digit scratch: any non-zero top digit means the value exceeded 9999
  assign sat = scratch_q[19:16] != 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  assign z3 = scratch_q[15:12] == 4'd0;
  assign z2 = z3 && scratch_q[11:8] == 4'd0;
  assign z1 = z2 && scratch_q[7:4] == 4'd0;
  assign disp = {z3 ? 4'hF : scratch_q[15:12], z2 ? 4'hF : scratch_q[11:8],
                 z1 ? 4'hF : scratch_q[7:4], scratch_q[3:0]};
`else
  assign disp = scratch_q[15:0];
`endif
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        shift_d   = bin_in;
        scratch_d = '0;
        cnt_d     = '0;
        busy_d    = 1'b1;
        state_d   = CONV;
      end
      CONV: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_WIDTH - 1)) begin
          busy_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = sat ? 16'h9999 : disp;
        ovf_d   = sat;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= RST_BCD;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
endmodule
